// File: rtl/siso_link_ctrl.sv
// -----------------------------------------------------------------------------
// siso_link_ctrl
//
// Moves parallel words through an external free-running serial-in/serial-out
// shift chain. Each accepted word goes out MSB-first on sin, one bit per
// cycle. A tag shift register of the same length as the chain marks which
// bits on sdo belong to a word. The marked bits are reassembled and
// presented as one out_valid pulse per word.
//
// Parameters
//   WIDTH  bits per word (>= 2)
//   DEPTH  number of register stages in the attached chain (>= 1)
//
// Ports
//   clk        rising-edge clock, shared with the shift chain
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a word on in_data
//   in_ready   word on in_data is accepted this cycle
//   in_data    word to transmit
//   sin        serial data into the chain
//   sdo        serial data out of the chain
//   out_valid  one-cycle pulse, out_data holds a received word
//   out_data   last reassembled word (held until the next one)
//   busy       transmitting, or some word bit is still inside the chain
// -----------------------------------------------------------------------------
module siso_link_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sin,
  input  logic             sdo,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tx_shift;
  logic [CW-1:0]    bit_cnt;
  logic [DEPTH-1:0] tags;
  logic [WIDTH-1:0] rx_shift;
  logic [CW-1:0]    rx_cnt;

  logic             sending;
  logic             last_bit;
  logic             accept;
  logic             tag_out;
  logic [DEPTH:0]   tags_ext;
  logic [WIDTH-1:0] rx_next;

  assign sending  = (state == SEND);
  assign last_bit = sending && (bit_cnt == LAST);

  // Gated by rst_n so the producer sees no acceptance while reset is held.
  assign in_ready = rst_n && (!sending || last_bit);
  assign accept   = in_valid && in_ready;

  // The tag entering the pipeline marks that sin carries a data bit this
  // cycle. After DEPTH edges it lines up with that bit on sdo. Building the
  // shift through a one-bit-wider vector keeps DEPTH=1 legal.
  assign tags_ext = {tags, sending};
  assign tag_out  = tags[DEPTH-1];

  assign rx_next  = {rx_shift[WIDTH-2:0], sdo};
  assign busy     = sending || (|tags);

  // Transmit FSM. sin is registered and always mirrors tx_shift[MSB] while
  // in SEND, so it is loaded directly from in_data on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_shift <= '0;
      bit_cnt  <= '0;
      sin      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= SEND;
            tx_shift <= in_data;
            bit_cnt  <= '0;
            sin      <= in_data[WIDTH-1];
          end else begin
            sin      <= 1'b0;
          end
        end
        SEND: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (accept) begin
              // Back-to-back: the next word's MSB follows the last bit
              // with no gap.
              tx_shift <= in_data;
              sin      <= in_data[WIDTH-1];
            end else begin
              state    <= IDLE;
              tx_shift <= '0;
              sin      <= 1'b0;
            end
          end else begin
            tx_shift <= tx_shift << 1;
            bit_cnt  <= bit_cnt + 1'b1;
            sin      <= tx_shift[WIDTH-2];
          end
        end
        default: begin
          state <= IDLE;
          sin   <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline, matched in length to the external chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else begin
      tags <= tags_ext[DEPTH-1:0];
    end
  end

  // Receive side. Only tagged bits are captured, so whatever the chain held
  // before reset (it is never cleared) cannot leak into a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift  <= '0;
      rx_cnt    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tag_out) begin
        rx_shift <= rx_next;
        if (rx_cnt == LAST) begin
          rx_cnt    <= '0;
          out_data  <= rx_next;
          out_valid <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_siso_link_ctrl.sv
`timescale 1ns/1ps
module tb_siso_link_ctrl;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int LAT = W + D + 1;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         force_one = 1'b0;
  logic         in_ready;
  logic         sin;
  logic         sdo;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         busy;
  logic [D-1:0] chain;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // Expected schedule derived from each observed handshake.
  bit           exp_sin[int];
  bit           last_b[int];
  int           time_q[$];
  logic [W-1:0] data_q[$];

  typedef struct {
    logic [W-1:0] data;
    int           gap;
    logic [W-1:0] exp_out;
  } vec_t;
  vec_t vecs[6];

  logic m_es, m_er, m_eb, m_eov;

  siso_link_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sin       (sin),
    .sdo       (sdo),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // External shift chain: free running, no reset, no enable.
  always @(posedge clk) begin
    chain <= {chain[D-2:0], (force_one ? 1'b1 : sin)};
    cyc   <= cyc + 1;
  end
  assign sdo = chain[D-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready",  32'(in_ready),  32'(0));
      check("rst_sin",       32'(sin),       32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_busy",      32'(busy),      32'(0));
      check("rst_out_data",  32'(out_data),  32'(0));
    end else begin
      m_es = exp_sin.exists(cyc) ? exp_sin[cyc] : 1'b0;
      m_er = !exp_sin.exists(cyc) || last_b.exists(cyc);
      m_eb = 1'b0;
      for (int c = cyc - D; c <= cyc; c++) begin
        if (exp_sin.exists(c)) m_eb = 1'b1;
      end
      m_eov = (time_q.size() > 0) && (time_q[0] == cyc);
      check("sin",       32'(sin),       32'(m_es));
      check("in_ready",  32'(in_ready),  32'(m_er));
      check("busy",      32'(busy),      32'(m_eb));
      check("out_valid", 32'(out_valid), 32'(m_eov));
      if (m_eov) begin
        void'(time_q.pop_front());
        check("word_expected", 32'(data_q.size() > 0), 32'(1));
        if (data_q.size() > 0) check("out_data", 32'(out_data), 32'(data_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < W; k++) exp_sin[cyc + 1 + k] = in_data[W-1-k];
        last_b[cyc + W] = 1'b1;
        time_q.push_back(cyc + LAT);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready), 32'(1));
    tick();
  endtask

  task automatic clear_model();
    exp_sin.delete();
    last_b.delete();
    time_q.delete();
    data_q.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || time_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'(1));
  endtask

  initial begin
    vecs[0] = '{8'hA5, 3, 8'hA5};
    vecs[1] = '{8'h3C, 0, 8'h3C};
    vecs[2] = '{8'hFF, 0, 8'hFF};
    vecs[3] = '{8'h01, 2, 8'h01};
    vecs[4] = '{8'h80, 5, 8'h80};
    vecs[5] = '{8'h7F, 3, 8'h7F};

    // Power-up reset.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Table-driven words: single, back-to-back and gapped.
    for (int i = 0; i < 6; i++) begin
      data_q.push_back(vecs[i].exp_out);
      send(vecs[i].data);
      if (vecs[i].gap > 0) begin
        in_valid = 1'b0;
        in_data  = ~vecs[i].data;
        repeat (vecs[i].gap) tick();
      end
    end
    in_valid = 1'b0;
    drain(60);

    // Reset in the middle of 0xC3 while in_valid stays high.
    data_q.push_back(8'hC3);
    send(8'hC3);
    in_data = 8'h11;
    repeat (5) tick();
    rst_n = 1'b0;
    clear_model();
    repeat (2) tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    data_q.push_back(8'h5A);
    send(8'h5A);
    in_valid = 1'b0;
    drain(60);

    // Chain pre-filled with ones, short reset, then a zero word.
    force_one = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    clear_model();
    #2;
    rst_n     = 1'b1;
    force_one = 1'b0;
    data_q.push_back(8'h00);
    send(8'h00);
    in_valid = 1'b0;
    drain(60);

    repeat (5) tick();
    check("words_left", 32'(data_q.size()), 32'(0));
    check("times_left", 32'(time_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
